// File: rtl/info_rf_regs.sv
// Control/status register file: node identification plus the four-slice r1 word,
// shared between a 64-bit software access port and hardware update inputs.
module info_rf_regs #(
    parameter logic [15:0] NODE_ID_RESET = 16'h0000,
    parameter logic [63:0] R1_RESET      = 64'h0
) (
    input  logic         clk,
    input  logic         res_n,
    input  logic [4:3]   address,
    input  logic         read_en,
    input  logic         write_en,
    input  logic [63:0]  write_data,
    output logic [63:0]  read_data,
    output logic         access_complete,
    output logic         invalid_address,
    output logic [15:0]  node_id,
    input  logic [23:0]  node_guid_next,
    input  logic [15:0]  r1_r1_1_next,
    output logic [15:0]  r1_r1_1,
    input  logic [15:0]  r1_r1_2_next,
    output logic [15:0]  r1_r1_2,
    output logic         r1_r1_2_written,
    input  logic [15:0]  r1_r1_3_next,
    output logic [15:0]  r1_r1_3,
    output logic         r1_r1_3_written,
    input  logic [15:0]  r1_r1_4_next,
    input  logic         r1_r1_4_wen,
    output logic [15:0]  r1_r1_4
);

    localparam logic [1:0] SLOT_NODE_ID   = 2'd0;
    localparam logic [1:0] SLOT_NODE_GUID = 2'd1;
    localparam logic [1:0] SLOT_R1        = 2'd2;

    logic [15:0] node_id_r;
    logic [23:0] node_guid_r;
    logic [15:0] r1_1_r;
    logic [15:0] r1_2_r;
    logic [15:0] r1_3_r;
    logic [15:0] r1_4_r;
    logic [63:0] read_data_r;
    logic        access_complete_r;
    logic        invalid_address_r;
    logic        r1_written_r;

    logic        req_s;
    logic        rd_s;
    logic        bad_s;
    logic        wr_node_id_s;
    logic        wr_r1_s;
    logic [63:0] rd_word_s;

    // Request decode; a simultaneous write wins over a read.
    always_comb begin
        req_s        = read_en | write_en;
        rd_s         = read_en & ~write_en;
        bad_s        = 1'b0;
        wr_node_id_s = 1'b0;
        wr_r1_s      = 1'b0;
        case (address)
            SLOT_NODE_ID:   wr_node_id_s = write_en;
            SLOT_NODE_GUID: wr_node_id_s = 1'b0;
            SLOT_R1:        wr_r1_s      = write_en;
            default:        bad_s        = req_s;
        endcase
    end

    // Read multiplexer over the pre-edge register contents.
    always_comb begin
        rd_word_s = 64'h0;
        case (address)
            SLOT_NODE_ID:   rd_word_s = {48'h0, node_id_r};
            SLOT_NODE_GUID: rd_word_s = {40'h0, node_guid_r};
            SLOT_R1:        rd_word_s = {r1_4_r, r1_3_r, r1_2_r, r1_1_r};
            default:        rd_word_s = 64'h0;
        endcase
    end

    // Register state: software writes to r1 take priority over hardware loads.
    always_ff @(posedge clk) begin
        if (res_n) begin
            node_id_r   <= NODE_ID_RESET;
            node_guid_r <= 24'h0;
            r1_1_r      <= R1_RESET[15:0];
            r1_2_r      <= R1_RESET[31:16];
            r1_3_r      <= R1_RESET[47:32];
            r1_4_r      <= R1_RESET[63:48];
        end else begin
            node_guid_r <= node_guid_next;
            if (wr_node_id_s) begin
                node_id_r <= write_data[15:0];
            end else begin
                node_id_r <= node_id_r;
            end
            if (wr_r1_s) begin
                r1_1_r <= write_data[15:0];
                r1_2_r <= write_data[31:16];
                r1_3_r <= write_data[47:32];
                r1_4_r <= write_data[63:48];
            end else begin
                r1_1_r <= r1_r1_1_next;
                r1_2_r <= r1_r1_2_next;
                r1_3_r <= r1_r1_3_next;
                if (r1_r1_4_wen) begin
                    r1_4_r <= r1_r1_4_next;
                end else begin
                    r1_4_r <= r1_4_r;
                end
            end
        end
    end

    // Access response: completion, error flag, read data and write pulses.
    always_ff @(posedge clk) begin
        if (res_n) begin
            read_data_r       <= 64'h0;
            access_complete_r <= 1'b0;
            invalid_address_r <= 1'b0;
            r1_written_r      <= 1'b0;
        end else begin
            access_complete_r <= req_s;
            invalid_address_r <= bad_s;
            r1_written_r      <= wr_r1_s;
            if (bad_s) begin
                read_data_r <= 64'h0;
            end else if (rd_s) begin
                read_data_r <= rd_word_s;
            end else begin
                read_data_r <= read_data_r;
            end
        end
    end

    assign read_data       = read_data_r;
    assign access_complete = access_complete_r;
    assign invalid_address = invalid_address_r;
    assign node_id         = node_id_r;
    assign r1_r1_1         = r1_1_r;
    assign r1_r1_2         = r1_2_r;
    assign r1_r1_3         = r1_3_r;
    assign r1_r1_4         = r1_4_r;
    assign r1_r1_2_written = r1_written_r;
    assign r1_r1_3_written = r1_written_r;

endmodule

// File: tb/tb_info_rf_regs.sv
// Scoreboard bench for info_rf_regs: a register-map model predicts every cycle's
// outputs, and a negedge monitor compares the DUT against the queued expectations.
module tb_info_rf_regs;

    logic        clk = 1'b0;
    logic        res_n;
    logic [1:0]  address;
    logic        read_en;
    logic        write_en;
    logic [63:0] write_data;
    logic [63:0] read_data;
    logic        access_complete;
    logic        invalid_address;
    logic [15:0] node_id;
    logic [23:0] node_guid_next;
    logic [15:0] n1, n2, n3, n4;
    logic        r1_r1_4_wen;
    logic [15:0] r1_r1_1, r1_r1_2, r1_r1_3, r1_r1_4;
    logic        r1_r1_2_written, r1_r1_3_written;

    always #5 clk = ~clk;

    info_rf_regs dut (
        .clk(clk), .res_n(res_n), .address(address), .read_en(read_en),
        .write_en(write_en), .write_data(write_data), .read_data(read_data),
        .access_complete(access_complete), .invalid_address(invalid_address),
        .node_id(node_id), .node_guid_next(node_guid_next),
        .r1_r1_1_next(n1), .r1_r1_1(r1_r1_1),
        .r1_r1_2_next(n2), .r1_r1_2(r1_r1_2), .r1_r1_2_written(r1_r1_2_written),
        .r1_r1_3_next(n3), .r1_r1_3(r1_r1_3), .r1_r1_3_written(r1_r1_3_written),
        .r1_r1_4_next(n4), .r1_r1_4_wen(r1_r1_4_wen), .r1_r1_4(r1_r1_4)
    );

    typedef struct {
        logic        ack;
        logic        inv;
        logic        pulse;
        logic [63:0] rdata;
        logic [15:0] nid;
        logic [15:0] r1 [4];
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference state of the register map
    logic [15:0] m_nid;
    logic [23:0] m_guid;
    logic [15:0] m_r1 [4];
    logic [63:0] m_rd;

    function automatic logic [63:0] slot_value(input logic [1:0] a);
        case (a)
            2'd0:    return {48'h0, m_nid};
            2'd1:    return {40'h0, m_guid};
            2'd2:    return {m_r1[3], m_r1[2], m_r1[1], m_r1[0]};
            default: return 64'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Advance one clock edge and push the model's prediction for it.
    task automatic step();
        exp_t e;
        logic [63:0] old_val;
        @(posedge clk);
        #1;
        e.ack = 1'b0; e.inv = 1'b0; e.pulse = 1'b0;
        if (res_n) begin
            m_nid = 16'h0; m_guid = 24'h0; m_rd = 64'h0;
            for (int k = 0; k < 4; k++) m_r1[k] = 16'h0;
        end else begin
            old_val = slot_value(address);
            e.ack   = read_en | write_en;
            e.inv   = e.ack && (address == 2'd3);
            e.pulse = write_en && (address == 2'd2);
            if (e.inv) m_rd = 64'h0;
            else if (read_en && !write_en) m_rd = old_val;
            m_guid  = node_guid_next;
            m_r1[0] = n1; m_r1[1] = n2; m_r1[2] = n3;
            if (r1_r1_4_wen) m_r1[3] = n4;
            if (write_en && address == 2'd0) m_nid = write_data[15:0];
            if (e.pulse) begin
                for (int k = 0; k < 4; k++) m_r1[k] = write_data[16*k +: 16];
            end
        end
        e.rdata = m_rd;
        e.nid   = m_nid;
        for (int k = 0; k < 4; k++) e.r1[k] = m_r1[k];
        exp_q.push_back(e);
    endtask

    task automatic req(input logic [1:0] a, input logic rd, input logic wr, input logic [63:0] wd);
        address = a; read_en = rd; write_en = wr; write_data = wd;
    endtask

    // Monitor: compare every cycle's outputs against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("access_complete", {63'h0, access_complete}, {63'h0, e.ack});
            chk("invalid_address", {63'h0, invalid_address}, {63'h0, e.inv});
            chk("read_data", read_data, e.rdata);
            chk("r1_2_written", {63'h0, r1_r1_2_written}, {63'h0, e.pulse});
            chk("r1_3_written", {63'h0, r1_r1_3_written}, {63'h0, e.pulse});
            chk("node_id", {48'h0, node_id}, {48'h0, e.nid});
            chk("r1_1", {48'h0, r1_r1_1}, {48'h0, e.r1[0]});
            chk("r1_2", {48'h0, r1_r1_2}, {48'h0, e.r1[1]});
            chk("r1_3", {48'h0, r1_r1_3}, {48'h0, e.r1[2]});
            chk("r1_4", {48'h0, r1_r1_4}, {48'h0, e.r1[3]});
        end
    end

    initial begin
        res_n = 1'b1;
        req(2'd0, 1'b0, 1'b0, 64'h0);
        node_guid_next = 24'h0; n1 = 16'h0; n2 = 16'h0; n3 = 16'h0; n4 = 16'h0;
        r1_r1_4_wen = 1'b0;
        m_nid = 16'h0; m_guid = 24'h0; m_rd = 64'h0;
        for (int k = 0; k < 4; k++) m_r1[k] = 16'h0;
        step(); step();
        res_n = 1'b0;

        // Directed scenarios
        node_guid_next = 24'hABCDEF;
        step();
        req(2'd1, 1'b1, 1'b0, 64'h0); step();
        req(2'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_1234); step();
        req(2'd0, 1'b1, 1'b0, 64'h0); step();
        n1 = 16'h5555; n2 = 16'h5555; n3 = 16'h5555; n4 = 16'h5555; r1_r1_4_wen = 1'b1;
        req(2'd2, 1'b0, 1'b1, 64'h4444_3333_2222_1111); step();
        req(2'd0, 1'b0, 1'b0, 64'h0); step();
        r1_r1_4_wen = 1'b0; n4 = 16'h7777; step(); step();
        r1_r1_4_wen = 1'b1; step();
        r1_r1_4_wen = 1'b0; step();
        req(2'd3, 1'b1, 1'b0, 64'h0); step();
        req(2'd3, 1'b0, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF); step();
        req(2'd2, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF); step();
        req(2'd2, 1'b1, 1'b0, 64'h0); step();
        req(2'd0, 1'b0, 1'b1, 64'h0000_0000_0000_BEEF); step();
        res_n = 1'b1; req(2'd0, 1'b0, 1'b0, 64'h0); step();
        res_n = 1'b0; step();

        // Randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            res_n = ($urandom_range(0, 39) == 0);
            req(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                {$urandom(), $urandom()});
            node_guid_next = 24'($urandom());
            n1 = 16'($urandom()); n2 = 16'($urandom()); n3 = 16'($urandom()); n4 = 16'($urandom());
            r1_r1_4_wen = 1'($urandom_range(0, 1));
            step();
        end

        res_n = 1'b0;
        req(2'd0, 1'b0, 1'b0, 64'h0);
        step();
        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/info_rf_regs.md
Name: info_rf_regs

Overview:
- Memory-mapped control/status register file holding node identification and four 16-bit general registers (group r1).
- Sits between a 64-bit software access port (address, read_en/write_en, read_data, access_complete, invalid_address) and hardware logic.
- Hardware logic supplies next values and consumes current values.
- Register map: 4 word slots of 64 bits, selected by address[4:3] (byte-address bits of 8-byte-aligned words).

Parameters:
- NODE_ID_RESET, 16'h0000, reset value of node_id.
- R1_RESET, 64'h0, reset value of the r1 word (slices as mapped below).

Ports:
- clk  in  1  clock; all logic on rising edge.
- res_n  in  1  synchronous reset, active-high: asserted when 1, sampled on rising clk.
- address  in  2 (bits [4:3])  word select.
- read_en  in  1  single-cycle read request.
- write_en  in  1  single-cycle write request.
- write_data  in  64  write value.
- read_data  out  64  registered read value.
- access_complete  out  1  one-cycle completion pulse.
- invalid_address  out  1  one-cycle error flag, valid with access_complete.
- node_id  out  16  current node_id register.
- node_guid_next  in  24  hardware value for node_guid, sampled every cycle.
- r1_r1_1_next  in  16  hardware value, sampled every cycle.
- r1_r1_1  out  16  current value.
- r1_r1_2_next  in  16  hardware value, sampled every cycle.
- r1_r1_2  out  16  current value.
- r1_r1_2_written  out  1  pulse on software write to r1.
- r1_r1_3_next  in  16  hardware value, sampled every cycle.
- r1_r1_3  out  16  current value.
- r1_r1_3_written  out  1  pulse on software write to r1.
- r1_r1_4_next  in  16  hardware value.
- r1_r1_4_wen  in  1  hardware write enable for r1_r1_4.
- r1_r1_4  out  16  current value.

Behaviour:
- Map by address[4:3]:
  - 0: node_id in [15:0]; software RW; [63:16] read 0, writes ignored.
  - 1: node_guid in [23:0]; software RO; writes ignored with no error; [63:24] read 0.
  - 2: r1 word: [15:0] r1_1, [31:16] r1_2, [47:32] r1_3, [63:48] r1_4; all software RW.
  - 3: unmapped.
- Reset (res_n=1 at clk edge): node_id=NODE_ID_RESET; node_guid=0; r1 slices from R1_RESET; read_data=0; access_complete=0; invalid_address=0; both written pulses 0.
- Hardware updates:
  - node_guid, r1_1, r1_2, r1_3 load their _next input every cycle.
  - r1_4 loads r1_r1_4_next only when r1_r1_4_wen=1, else holds.
- Priority: a software write to slot 2 in a cycle overrides all hardware updates to r1 slices in that cycle.
- Access timing: a request at edge N gives access_complete=1 for exactly the cycle after edge N (one-cycle latency). read_data and invalid_address are valid in that same cycle.
- Read: read_data = register contents before edge N; hardware updates at edge N are not visible.
- read_data holds its last value when no read completes. Writes do not change read_data.
- Write: register updated at edge N. r1_r1_2_written and r1_r1_3_written both pulse 1 for one cycle, coincident with access_complete, on any write to slot 2.
- Slot 3: read or write sets access_complete=1 and invalid_address=1; read_data=0; no state change.
- read_en and write_en together: the write is performed, the read is ignored, and a single access_complete is generated.
- Back-to-back requests on consecutive cycles are each completed; no stalling.
- Reset mid-access: pending completion is cancelled; no pulse is generated after reset.

Test Plan:
- Reset: hold res_n=1 for 2 cycles -> node_id=0, r1_* = 0, access_complete=0, invalid_address=0, written pulses=0.
- node_guid_next=24'hABCDEF held, read slot 1 -> next cycle access_complete=1, read_data=64'h0000_0000_00AB_CDEF, invalid_address=0.
- Write slot 0 with 64'hFFFF_FFFF_FFFF_1234 -> node_id=16'h1234; read back returns 64'h1234.
- Write slot 2 with 64'h4444_3333_2222_1111 while all _next=16'h5555 and r1_r1_4_wen=1:
  - next cycle: r1_1=1111, r1_2=2222, r1_3=3333, r1_4=4444; both written pulses=1 for one cycle.
  - following cycle: r1_1..3=5555, r1_4=5555.
- r1_r1_4_wen=0, r1_r1_4_next=16'h7777 -> r1_r1_4 unchanged. Pulse wen=1 for one cycle -> r1_r1_4=7777.
- Read slot 3 and write slot 3 -> access_complete=1 with invalid_address=1, read_data=0, no register changes.
